// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the max-pooling controller.
package pool_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } pool_state_t;

    // Counter width for a 0..n-1 range; a 1-entry range still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_cmp.sv
// Running-max select for the external max register.
// MAXPOOL_SIGNED_EN selects a two's-complement compare; default is unsigned.
module max_cmp #(
    parameter int N = 8
) (
    input  logic         first,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    logic a_gt_b;

`ifdef MAXPOOL_SIGNED_EN
    assign a_gt_b = $signed(a) > $signed(b);
`else
    assign a_gt_b = a > b;
`endif

    // The first element of a window ignores whatever the register still holds.
    assign y = (first || a_gt_b) ? a : b;

endmodule

// File: rtl/max_pool_ctrl.sv
// Max-pooling sequencer: drives an external running-max register and
// returns one pooled value per window. MAXPOOL_SIGNED_EN picks signed compare.
module max_pool_ctrl
    import pool_pkg::*;
#(
    parameter int N       = 8,
    parameter int WIN     = 4,
    parameter int NUM_WIN = 16
) (
    input  logic         clk,
    input  logic         master_rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         mreg_ce,
    output logic         mreg_rst_m,
    output logic [N-1:0] mreg_din,
    input  logic [N-1:0] mreg_q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last
);

    localparam int KW = cnt_w(WIN);
    localparam int WW = cnt_w(NUM_WIN);
    localparam logic [KW-1:0] K_LAST = KW'(WIN - 1);
    localparam logic [WW-1:0] W_LAST = WW'(NUM_WIN - 1);

    pool_state_t   state;
    logic [KW-1:0] k;
    logic [WW-1:0] w;
    logic          accept;
    logic [N-1:0]  sel_max;

    // flush masks both handshakes so nothing transfers in the abort cycle
    assign in_ready   = (state == ACCUM) && !flush;
    assign out_valid  = (state == DRAIN) && !flush;
    assign out_last   = out_valid && (w == W_LAST);
    assign out_data   = mreg_q;
    assign accept     = in_valid && in_ready;

    assign mreg_ce    = flush || accept;
    assign mreg_rst_m = flush;
    assign mreg_din   = accept ? sel_max : '0;

    max_cmp #(.N(N)) u_cmp (
        .first (k == '0),
        .a     (in_data),
        .b     (mreg_q),
        .y     (sel_max)
    );

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state <= ACCUM;
            k     <= '0;
            w     <= '0;
        end else if (flush) begin
            state <= ACCUM;
            k     <= '0;
            w     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= DRAIN;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        w     <= (w == W_LAST) ? '0 : w + WW'(1);
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Scoreboard bench for max_pool_ctrl with a behavioural max register attached.
module tb_max_pool_ctrl;

    localparam int N = 8;
    localparam int WIN = 4;
    localparam int NUM_WIN = 2;

    logic         clk = 1'b0;
    logic         master_rst_n = 1'b0;
    logic         mreg_rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         mreg_ce;
    logic         mreg_rst_m;
    logic [N-1:0] mreg_din;
    logic [N-1:0] mreg_q;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_last;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N-1:0] d;
        logic         l;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] m_win[$];
    bit           m_drain = 0;
    int           m_w = 0;

    always #5 clk = ~clk;

    max_pool_ctrl #(.N(N), .WIN(WIN), .NUM_WIN(NUM_WIN)) dut (
        .clk          (clk),
        .master_rst_n (master_rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mreg_ce      (mreg_ce),
        .mreg_rst_m   (mreg_rst_m),
        .mreg_din     (mreg_din),
        .mreg_q       (mreg_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    // External max_reg: own reset, synchronous clear via rst_m when enabled.
    always_ff @(posedge clk or negedge mreg_rst_n) begin
        if (!mreg_rst_n)   mreg_q <= '0;
        else if (mreg_ce)  mreg_q <= mreg_rst_m ? '0 : mreg_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_max(input logic [N-1:0] q[$]);
        logic [N-1:0] m = q[0];
        foreach (q[i]) begin
`ifdef MAXPOOL_SIGNED_EN
            if ($signed(q[i]) > $signed(m)) m = q[i];
`else
            if (q[i] > m) m = q[i];
`endif
        end
        return m;
    endfunction

    // One clock of stimulus; control outputs checked against the model mid-cycle.
    task automatic cycle(input logic v, input logic [N-1:0] d, input logic rdy, input logic fl);
        bit exp_ready, acc;
        in_valid = v; in_data = d; out_ready = rdy; flush = fl;
        exp_ready = !fl && !m_drain;
        acc = v && exp_ready;
        @(negedge clk);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, !fl && m_drain);
        chk("mreg_ce", mreg_ce, fl || acc);
        chk("mreg_rst_m", mreg_rst_m, fl);
        @(posedge clk);
        if (fl) begin
            m_win.delete(); m_drain = 0; m_w = 0;
        end else if (m_drain) begin
            if (rdy) begin m_drain = 0; m_w = (m_w + 1) % NUM_WIN; end
        end else if (v) begin
            m_win.push_back(d);
            if (m_win.size() == WIN) begin
                sb.push_back('{d: ref_max(m_win), l: (m_w == NUM_WIN - 1)});
                m_win.delete();
                m_drain = 1;
            end
        end
        #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic window(input logic [N-1:0] a, b, c, e);
        cycle(1, a, 0, 0); cycle(1, b, 0, 0); cycle(1, c, 0, 0); cycle(1, e, 0, 0);
    endtask

    task automatic drain_out();
        int n = 0;
        while (m_drain && n < 100) begin
            cycle(0, '0, (n >= 10) || ($urandom_range(0, 1) == 1), 0);
            n++;
        end
    endtask

    // Monitor: peeks the expected result while valid, pops on handshake.
    always @(negedge clk) begin
        if (master_rst_n && out_valid) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL out_unexpected: got data %0h with no result pending", out_data);
            end else begin
                chk("out_data", out_data, sb[0].d);
                chk("out_last", out_last, sb[0].l);
                chk("in_ready_drain", in_ready, 0);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mreg_ce", mreg_ce, 0);
        chk("rst_mreg_rst_m", mreg_rst_m, 0);
        chk("rst_mreg_din", mreg_din, 0);
        @(posedge clk); #1;
        master_rst_n = 1'b1; mreg_rst_n = 1'b1;

        // basic window, then backpressure for 5 cycles with in_valid high
        window(8'd3, 8'd9, 8'd5, 8'd7);
        repeat (5) cycle(1, 8'hAA, 0, 0);
        cycle(0, '0, 1, 0);
        // last window then wrap
        window(8'd1, 8'd1, 8'd1, 8'd1);
        cycle(0, '0, 1, 0);
        window(8'd8, 8'd2, 8'd2, 8'd2);
        cycle(0, '0, 1, 0);

        // flush mid-window
        cycle(1, 8'd200, 0, 0);
        cycle(1, 8'd100, 0, 0);
        cycle(1, 8'd55, 1, 1);
        chk("flush_mreg_q", mreg_q, 0);
        window(8'd4, 8'd3, 8'd2, 8'd1);
        drain_out();

        // compare mode
        window(8'h05, 8'hF0, 8'h02, 8'h01);
        drain_out();

        // reset mid-window; max_reg keeps stale 200
        cycle(1, 8'd200, 0, 0);
        cycle(1, 8'd150, 0, 0);
        master_rst_n = 1'b0;
        m_win.delete(); m_drain = 0; m_w = 0;
        @(negedge clk);
        chk("rstmid_out_valid", out_valid, 0);
        @(posedge clk); #1;
        master_rst_n = 1'b1;
        window(8'd6, 8'd1, 8'd1, 8'd1);
        drain_out();

        // randomized traffic with gaps, backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            if (m_drain) cycle($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 2) == 0, 0);
            else cycle($urandom_range(0, 3) != 0, 8'($urandom), 0, $urandom_range(0, 40) == 0);
        end
        drain_out();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
